// File: rtl/mem_access_stage.sv
// mem_access_stage: LEGv8 memory stage.
// Holds the EX/MEM pipeline register, resolves conditional branches, and runs a
// ready-handshaked load/store against data memory. Upstream is stalled while an
// access is outstanding. A registered writeback result is presented one cycle
// after the result becomes known.
module mem_access_stage #(
   parameter int unsigned N           = 64,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         reset,

   // Execute-stage results and control
   input  logic         valid_E,
   input  logic         MemRead_E,
   input  logic         MemWrite_E,
   input  logic         RegWrite_E,
   input  logic         MemtoReg_E,
   input  logic         Branch_E,
   input  logic [4:0]   rd_E,
   input  logic [N-1:0] PCBranch_E,
   input  logic [N-1:0] aluResult_E,
   input  logic [N-1:0] writeData_E,
   input  logic         zero_E,

   // Pipeline control back to fetch/execute
   output logic         stall_M,
   output logic         PCSrc_M,
   output logic [N-1:0] PCBranch_M,

   // Data memory port
   output logic         dm_read,
   output logic         dm_write,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic         dm_ready,
   input  logic [N-1:0] dm_rdata,

   // Writeback
   output logic         wb_valid,
   output logic         RegWrite_W,
   output logic [4:0]   rd_W,
   output logic [N-1:0] wbData_W,
   output logic         mem_err
);

   // Wide enough to hold 0..MEM_TIMEOUT.
   localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [0:0] {
      StIdle,
      StAccess
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // EX/MEM register
   logic            m_valid;
   logic            MemRead_M;
   logic            MemWrite_M;
   logic            RegWrite_M;
   logic            MemtoReg_M;
   logic            Branch_M;
   logic            zero_M;
   logic [4:0]      rd_M;
   logic [N-1:0]    aluResult_M;
   logic [N-1:0]    writeData_M;

   logic            capture;
   logic            mem_op_E;
   logic            in_access;
   logic            timeout;
   logic            illegal_M;
   logic            wb_load_alu;
   logic            wb_load_mem;
   logic            wb_load;
   logic [N-1:0]    wb_data_d;

   // Control decodes; all outputs below come from registered state only.
   always_comb begin
      in_access   = (state_q == StAccess);
      stall_M     = in_access;
      capture     = valid_E & ~in_access;
      mem_op_E    = MemRead_E ^ MemWrite_E;
      timeout     = in_access & ~dm_ready & (cnt_q == CntW'(MEM_TIMEOUT - 1));
      illegal_M   = m_valid & MemRead_M & MemWrite_M;
      PCSrc_M     = m_valid & Branch_M & zero_M;
      dm_read     = in_access & MemRead_M;
      dm_write    = in_access & MemWrite_M;
      dm_addr     = aluResult_M;
      dm_wdata    = writeData_M;
      wb_load_alu = m_valid & ~MemRead_M & ~MemWrite_M;
      wb_load_mem = in_access & dm_ready;
      wb_load     = wb_load_alu | wb_load_mem;
      // Only a completed load with MemtoReg returns memory data.
      wb_data_d   = (wb_load_mem & MemRead_M & MemtoReg_M) ? dm_rdata : aluResult_M;
   end

   // Next-state logic for the access FSM and its timeout counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (capture && mem_op_E) begin
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (dm_ready || timeout) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM state and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // EX/MEM register: loads only when upstream is not being held off.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid     <= 1'b0;
         MemRead_M   <= 1'b0;
         MemWrite_M  <= 1'b0;
         RegWrite_M  <= 1'b0;
         MemtoReg_M  <= 1'b0;
         Branch_M    <= 1'b0;
         zero_M      <= 1'b0;
         rd_M        <= '0;
         PCBranch_M  <= '0;
         aluResult_M <= '0;
         writeData_M <= '0;
      end else begin
         m_valid <= capture;
         if (capture) begin
            MemRead_M   <= MemRead_E;
            MemWrite_M  <= MemWrite_E;
            RegWrite_M  <= RegWrite_E;
            MemtoReg_M  <= MemtoReg_E;
            Branch_M    <= Branch_E;
            zero_M      <= zero_E;
            rd_M        <= rd_E;
            PCBranch_M  <= PCBranch_E;
            aluResult_M <= aluResult_E;
            writeData_M <= writeData_E;
         end
      end
   end

   // Writeback register: one-cycle valid pulse per retired op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid   <= 1'b0;
         RegWrite_W <= 1'b0;
         rd_W       <= '0;
         wbData_W   <= '0;
      end else begin
         wb_valid   <= wb_load;
         RegWrite_W <= wb_load & RegWrite_M;
         if (wb_load) begin
            rd_W     <= rd_M;
            wbData_W <= wb_data_d;
         end
      end
   end

   // Sticky error: illegal read+write op or memory timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_err <= 1'b0;
      end else if (illegal_M || timeout) begin
         mem_err <= 1'b1;
      end
   end

endmodule
